// File: rtl/frame_rx.sv
`default_nettype none
// ============================================================================
// frame_rx : locks onto a sync byte, gathers a checksummed fixed-length
//            payload and publishes it atomically on a good frame.
// Rev 1.0
// ============================================================================
module frame_rx #(
  parameter int         FRAME_LEN    = 20,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         GAP_CYCLES   = 50000,
  parameter int         STALE_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] data [FRAME_LEN-1:0],
  output logic       frame_ok,
  output logic       frame_err,
  output logic       stale
);

  localparam int IDX_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         shadow [FRAME_LEN-1:0];
  logic [IDX_W-1:0]   idx;
  logic [7:0]         sum;
  logic [GAP_W-1:0]   gap_cnt;
  logic [STALE_W-1:0] stale_cnt;
  logic               gap_expire;
  logic               good;

  // The timeout fires in the idle cycle that would take the counter to
  // GAP_CYCLES; a byte arriving in that same cycle is accepted instead.
  always_comb begin
    gap_expire = 1'b0;
    good       = 1'b0;
    gap_expire = (state != HUNT) && !rx_valid && (gap_cnt == GAP_LAST);
    good       = (state == CHECK) && rx_valid && (rx_data == sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      idx       <= '0;
      sum       <= '0;
      gap_cnt   <= '0;
      stale_cnt <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      stale     <= 1'b1;
      for (int i = 0; i < FRAME_LEN; i++) begin
        data[i]   <= 8'h00;
        shadow[i] <= 8'h00;
      end
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // stale is sticky from reset until the first good frame arrives
      if (good) begin
        stale_cnt <= '0;
        stale     <= 1'b0;
      end else begin
        if (stale_cnt != STALE_MAX) begin
          stale_cnt <= stale_cnt + 1'b1;
        end
        if (stale_cnt >= STALE_MAX - 1'b1) begin
          stale <= 1'b1;
        end
      end

      case (state)
        HUNT: begin
          gap_cnt <= '0;
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            idx   <= '0;
            sum   <= '0;
            state <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (rx_valid) begin
            shadow[idx] <= rx_data;
            sum         <= sum + rx_data;
            gap_cnt     <= '0;
            if (idx == LAST_IDX) begin
              state <= CHECK;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (gap_expire) begin
            frame_err <= 1'b1;
            gap_cnt   <= '0;
            state     <= HUNT;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (rx_valid) begin
            gap_cnt <= '0;
            state   <= HUNT;
            if (good) begin
              frame_ok <= 1'b1;
              for (int i = 0; i < FRAME_LEN; i++) begin
                data[i] <= shadow[i];
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else if (gap_expire) begin
            frame_err <= 1'b1;
            gap_cnt   <= '0;
            state     <= HUNT;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule
`default_nettype wire
